// File: rtl/clock_adjust_controller.sv
// -----------------------------------------------------------------------------
// clock_adjust_controller
//
// Mode/adjust sequencer sitting between the raw push-buttons and the
// seconds-minutes-hours time counter. It shares the counter's clock.
//
//   RUN     : the counter runs freely (en=1), up/down buttons are ignored.
//   ADJ_MIN : the counter is frozen, up/down presses step minutes via en1.
//   ADJ_HR  : the counter is frozen, up/down presses step hours via en2.
//
// Holding a step button auto-repeats: the first repeat comes HOLD_CYCLES
// cycles after the initial step, then one every REPEAT_CYCLES cycles.
// Sitting in an adjust mode with nothing pressed for IDLE_TIMEOUT cycles
// drops back to RUN.
//
// Ports
//   clk_out  in   system clock (same as the time counter)
//   reset    in   asynchronous, active-low reset
//   btn_mode in   raw mode button, asynchronous, active-high
//   btn_up   in   raw increment button, asynchronous, active-high
//   btn_down in   raw decrement button, asynchronous, active-high
//   en       out  counter run enable, 1 only in RUN
//   en1      out  one-cycle minutes step pulse (ADJ_MIN only)
//   en2      out  one-cycle hours step pulse (ADJ_HR only)
//   up_down  out  step direction, 1 = up, 0 = down
//   mode     out  current state: 00 RUN, 01 ADJ_MIN, 10 ADJ_HR
// -----------------------------------------------------------------------------
module clock_adjust_controller #(
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 64
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       en,
  output logic       en1,
  output logic       en2,
  output logic       up_down,
  output logic [1:0] mode
);

  localparam int MAX_CNT = (HOLD_CYCLES > IDLE_TIMEOUT) ? HOLD_CYCLES : IDLE_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HOLD_LAST     = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_RELOAD = CW'(HOLD_CYCLES - REPEAT_CYCLES);
  localparam logic [CW-1:0] IDLE_LAST     = CW'(IDLE_TIMEOUT - 1);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_ADJ_MIN = 2'b01;
  localparam logic [1:0] ST_ADJ_HR  = 2'b10;

  // Button vectors are ordered {down, up, mode}.
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    prev_q, prev_d;

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d;
  logic          en1_q, en1_d;
  logic          en2_q, en2_d;
  logic          up_down_q, up_down_d;

  logic          hold_act_q, hold_act_d;
  logic          hold_dir_q, hold_dir_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  logic [2:0]    rise;
  logic          mode_s, up_s, dn_s, any_s;
  logic          in_adj, timeout;
  logic          step_up_req, step_dn_req;
  logic          held_same;
  logic          pulse;
  logic          pulse_dir;

  // Two-flop synchronizer followed by a previous-value flop for edge detect.
  always_comb begin
    sync1_d = {btn_down, btn_up, btn_mode};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Conditioned button levels and the decisions derived from them.
  always_comb begin
    mode_s = sync2_q[0];
    up_s   = sync2_q[1];
    dn_s   = sync2_q[2];
    any_s  = |sync2_q;
    rise   = sync2_q & ~prev_q;

    in_adj  = (state_q != ST_RUN);
    timeout = in_adj && (idle_cnt_q == IDLE_LAST);

    // A rise only counts as a step when the opposite button is not also high;
    // this covers both simultaneous rises and one button already being held.
    step_up_req = rise[1] & ~dn_s;
    step_dn_req = rise[2] & ~up_s;

    // Auto-repeat keeps going only while the original button alone is held.
    held_same = hold_dir_q ? (up_s & ~dn_s) : (dn_s & ~up_s);
  end

  // Next-state, step pulse, hold counter and idle counter.
  always_comb begin
    state_d    = state_q;
    up_down_d  = up_down_q;
    hold_act_d = hold_act_q;
    hold_dir_d = hold_dir_q;
    hold_cnt_d = hold_cnt_q;
    idle_cnt_d = idle_cnt_q;
    pulse      = 1'b0;
    pulse_dir  = 1'b1;

    // Timeout has priority over a mode press; an illegal state recovers to RUN.
    if (timeout) begin
      state_d = ST_RUN;
    end else if (rise[0]) begin
      case (state_q)
        ST_RUN:     state_d = ST_ADJ_MIN;
        ST_ADJ_MIN: state_d = ST_ADJ_HR;
        default:    state_d = ST_RUN;
      endcase
    end else if (state_q == 2'b11) begin
      state_d = ST_RUN;
    end

    // Steps only happen in an adjust mode on a cycle with no mode change
    // and no timeout; anything else drops the auto-repeat.
    if (in_adj && !timeout && !rise[0] && state_q != 2'b11) begin
      if (step_up_req || step_dn_req) begin
        pulse      = 1'b1;
        pulse_dir  = step_up_req;
        hold_act_d = 1'b1;
        hold_dir_d = step_up_req;
        hold_cnt_d = '0;
      end else if (hold_act_q) begin
        if (!held_same) begin
          hold_act_d = 1'b0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Reloading to HOLD-REPEAT makes later repeats REPEAT_CYCLES apart.
          pulse      = 1'b1;
          pulse_dir  = hold_dir_q;
          hold_cnt_d = REPEAT_RELOAD;
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
    end else begin
      hold_act_d = 1'b0;
      hold_cnt_d = '0;
    end

    if (pulse) begin
      up_down_d = pulse_dir;
    end

    // Direction defaults back to up whenever the counter is running.
    if (state_d == ST_RUN) begin
      up_down_d = 1'b1;
    end

    // Idle counter only advances in adjust modes with every button released.
    if (!in_adj || state_d == ST_RUN || any_s) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_LAST) begin
      idle_cnt_d = idle_cnt_q + CW'(1);
    end

    en_d  = (state_d == ST_RUN);
    en1_d = pulse && (state_q == ST_ADJ_MIN);
    en2_d = pulse && (state_q == ST_ADJ_HR);
  end

  // All state and outputs are registered; reset forces RUN immediately.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      state_q    <= ST_RUN;
      en_q       <= 1'b1;
      en1_q      <= 1'b0;
      en2_q      <= 1'b0;
      up_down_q  <= 1'b1;
      hold_act_q <= 1'b0;
      hold_dir_q <= 1'b1;
      hold_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      en_q       <= en_d;
      en1_q      <= en1_d;
      en2_q      <= en2_d;
      up_down_q  <= up_down_d;
      hold_act_q <= hold_act_d;
      hold_dir_q <= hold_dir_d;
      hold_cnt_q <= hold_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign en      = en_q;
  assign en1     = en1_q;
  assign en2     = en2_q;
  assign up_down = up_down_q;
  assign mode    = state_q;

endmodule

// File: tb/tb_clock_adjust_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_adjust_controller
//
// Directed bench for clock_adjust_controller with default parameters.
// Stimulus pushes the hand-computed output events it expects into a
// scoreboard queue; a monitor on the falling clock edge pops and compares
// whenever the DUT shows a step pulse or a mode change.
// Event packing: outs = {en, en1, en2, up_down, mode}.
// -----------------------------------------------------------------------------
module tb_clock_adjust_controller;

  typedef struct packed {
    int         cyc;
    logic [5:0] outs;
  } sb_entry_t;

  logic       clk_out;
  logic       reset;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       en;
  logic       en1;
  logic       en2;
  logic       up_down;
  logic [1:0] mode;

  int         cycleCount;
  int         checkCount;
  int         errorCount;
  int         base;
  logic [1:0] lastMode;
  sb_entry_t  sbQueue[$];
  sb_entry_t  expEntry;

  clock_adjust_controller dut (
    .clk_out  (clk_out),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .en       (en),
    .en1      (en1),
    .en2      (en2),
    .up_down  (up_down),
    .mode     (mode)
  );

  // Free-running 10 ns clock.
  initial begin
    clk_out = 1'b0;
    forever #5 clk_out = ~clk_out;
  end

  // Rising-edge counter used to time-stamp expected and observed events.
  always @(posedge clk_out or negedge reset) begin
    if (!reset) cycleCount <= 0;
    else        cycleCount <= cycleCount + 1;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actCyc, input int expCyc,
                             input logic [5:0] act, input logic [5:0] expv);
    checkCount++;
    if (act !== expv || actCyc != expCyc) begin
      errorCount++;
      $display("[TB] FAIL %s: got cycle %0d outs %b, expected cycle %0d outs %b",
               name, actCyc, act, expCyc, expv);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk_out);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic m, input logic u, input logic d, input int hold);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    waitCycles(hold);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic expectEvent(input int cyc, input logic e, input logic e1, input logic e2,
                             input logic ud, input logic [1:0] md);
    sb_entry_t entry;
    entry.cyc  = cyc;
    entry.outs = {e, e1, e2, ud, md};
    sbQueue.push_back(entry);
  endtask

  // Scoreboard monitor: any pulse or mode change is an event to be matched.
  always @(negedge clk_out) begin
    if (!reset) begin
      lastMode = mode;
    end else if (en1 || en2 || mode != lastMode) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedEvent", cycleCount, -1, {en, en1, en2, up_down, mode}, 6'b000000);
        if ({en, en1, en2, up_down, mode} == 6'b000000) begin
          errorCount++;
          $display("[TB] FAIL unexpectedEvent: got event at cycle %0d, expected none", cycleCount);
        end
      end else begin
        expEntry = sbQueue.pop_front();
        checkOutput("event", cycleCount, expEntry.cyc, {en, en1, en2, up_down, mode}, expEntry.outs);
      end
      lastMode = mode;
    end
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    lastMode   = 2'b00;
    reset      = 1'b0;
    btn_mode   = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;

    // Reset state, then up/down presses in RUN must produce nothing.
    waitCycles(3);
    checkOutput("resetValues", 0, 0, {en, en1, en2, up_down, mode}, 6'b100100);
    reset = 1'b1;
    waitCycles(3);
    checkOutput("afterRelease", 0, 0, {en, en1, en2, up_down, mode}, 6'b100100);
    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    waitCycles(4);

    // Full mode cycle RUN -> ADJ_MIN -> ADJ_HR -> RUN.
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(4);
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(4);
    base = cycleCount; expectEvent(base + 3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(4);

    // Minutes stepping: down, up, down.
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(4);
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1, 3); waitCycles(4);
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 3); waitCycles(4);
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1, 3); waitCycles(4);

    // Into ADJ_HR keeping the down direction, then auto-repeat on a 40-cycle hold.
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(4);
    base = cycleCount;
    expectEvent(base + 3,  1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 19, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 23, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 27, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 31, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 35, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 39, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0, 40); waitCycles(6);
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b1, 3); waitCycles(4);
    base = cycleCount; expectEvent(base + 3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(4);

    // Idle timeout from ADJ_MIN.
    base = cycleCount;
    expectEvent(base + 3,  1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    expectEvent(base + 69, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(70);

    // Both step buttons together, then mode together with up: no pulses.
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 3); waitCycles(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 3); waitCycles(4);
    base = cycleCount; expectEvent(base + 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    applyStimulus(1'b1, 1'b1, 1'b0, 3); waitCycles(4);

    // Reset in the middle of auto-repeat in ADJ_HR.
    base = cycleCount;
    expectEvent(base + 3,  1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 19, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    expectEvent(base + 23, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    btn_up = 1'b1;
    waitCycles(25);
    reset = 1'b0;
    #1;
    checkOutput("midAdjustReset", 0, 0, {en, en1, en2, up_down, mode}, 6'b100100);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(20);
    checkOutput("heldThroughRelease", 0, 0, {en, en1, en2, up_down, mode}, 6'b100100);
    btn_up = 1'b0;
    waitCycles(6);

    checkOutput("scoreboardDrained", sbQueue.size(), 0, 6'b000000, 6'b000000);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
